// File: rtl/gcd_drv_pkg.sv
// Shared types and constants for the GCD processor stimulus driver.
// Holds the FSM state enum, LFSR parameters and default timing values.
package gcd_drv_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GENX,
    S_GENY,
    S_PRST,
    S_GAP1,
    S_ENTX,
    S_GAP2,
    S_ENTY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_GAP1    = 4;
  localparam int DEF_GAP2    = 7;
  localparam int DEF_TIMEOUT = 1023;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gcd_ref_model.sv
// Subtractive GCD reference: one subtraction per clock after start.
// done is high while a loaded pair has converged; gcd is then valid.
module gcd_ref_model (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       done,
  output logic [7:0] gcd
);

  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       r_run;

  // Load on start, then subtract smaller from larger until equal
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_x   <= 8'd0;
      r_y   <= 8'd0;
      r_run <= 1'b0;
    end else if (start) begin
      r_x   <= a;
      r_y   <= b;
      r_run <= 1'b1;
    end else if (r_run && (r_x != r_y)) begin
      if (r_x > r_y) r_x <= r_x - r_y;
      else           r_y <= r_y - r_x;
    end
  end

  assign done = r_run && (r_x == r_y);
  assign gcd  = r_x;

endmodule

// File: rtl/gcd_stim_driver.sv
// Host-side self-test driver for the subtractive GCD processor.
// Generates operands, strobes them in, waits for Halt, checks Output.
module gcd_stim_driver
  import gcd_drv_pkg::*;
#(
  parameter int         NUM_TESTS = 100,
  parameter logic [7:0] SEED      = 8'h5A,
  parameter int         LOAD_GAP1 = DEF_GAP1,
  parameter int         LOAD_GAP2 = DEF_GAP2,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Halt,
  input  logic [7:0] Output,
  output logic       ProcReset_n,
  output logic       Enter,
  output logic [7:0] Input,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic       Timeout,
  output logic [7:0] ErrCount,
  output logic [7:0] TestCount,
  output logic [7:0] CurX,
  output logic [7:0] CurY
);

  localparam logic [15:0] GAP1_END = 16'(LOAD_GAP1 - 1);
  localparam logic [15:0] GAP2_END = 16'(LOAD_GAP2 - 2);
  localparam logic [15:0] TMO_END  = 16'(TIMEOUT - 1);
  localparam logic [8:0]  LAST_TC  = 9'(NUM_TESTS);

  state_t             r_state;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [15:0]        r_cnt;
  logic               r_cmp;
  logic               r_prst_n;
  logic               r_enter;
  logic [7:0]         r_input;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_tmo;
  logic [7:0]         r_err;
  logic [7:0]         r_tc;
  logic [7:0]         r_curx;
  logic [7:0]         r_cury;

  logic [LFSR_W-1:0]  w_lfsr_nxt;
  logic               w_ref_start;
  logic               w_ref_done;
  logic [7:0]         w_ref_gcd;
  logic [7:0]         w_err_inc;
  logic [7:0]         w_err_nxt;
  logic [8:0]         w_tc_nxt;

  assign w_lfsr_nxt  = lfsr_step(r_lfsr);
  assign w_ref_start = (r_state == S_PRST);
  assign w_err_inc   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_err_nxt   = (r_cmp && (Output != w_ref_gcd)) ? w_err_inc : r_err;
  assign w_tc_nxt    = {1'b0, r_tc} + 9'd1;

  gcd_ref_model u_ref (
    .Clock (Clock),
    .Reset (Reset),
    .start (w_ref_start),
    .a     (r_curx),
    .b     (r_cury),
    .done  (w_ref_done),
    .gcd   (w_ref_gcd)
  );

  // Test sequencer: operand generation, load strobes, wait and scoring
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_cnt    <= 16'd0;
      r_cmp    <= 1'b0;
      r_prst_n <= 1'b0;
      r_enter  <= 1'b0;
      r_input  <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_tmo    <= 1'b0;
      r_err    <= 8'd0;
      r_tc     <= 8'd0;
      r_curx   <= 8'd0;
      r_cury   <= 8'd0;
    end else begin
      r_enter <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_prst_n <= 1'b1;
          if (Start) begin
            r_state <= S_GENX;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= 8'd0;
            r_tc    <= 8'd0;
          end
        end
        S_GENX: begin
          r_lfsr <= w_lfsr_nxt;
          if (w_lfsr_nxt[6:0] != 7'd0) begin
            r_curx  <= {1'b0, w_lfsr_nxt[6:0]};
            r_state <= S_GENY;
          end
        end
        S_GENY: begin
          r_lfsr <= w_lfsr_nxt;
          if (w_lfsr_nxt[6:0] != 7'd0) begin
            r_cury   <= {1'b0, w_lfsr_nxt[6:0]};
            r_prst_n <= 1'b0;
            r_state  <= S_PRST;
          end
        end
        S_PRST: begin
          r_prst_n <= 1'b1;
          r_cnt    <= 16'd0;
          r_state  <= S_GAP1;
        end
        S_GAP1: begin
          if (r_cnt == GAP1_END) begin
            r_enter <= 1'b1;
            r_input <= r_curx;
            r_state <= S_ENTX;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_ENTX: begin
          r_cnt   <= 16'd0;
          r_state <= S_GAP2;
        end
        S_GAP2: begin
          if (r_cnt == GAP2_END) begin
            r_enter <= 1'b1;
            r_input <= r_cury;
            r_state <= S_ENTY;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_ENTY: begin
          r_cnt   <= 16'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Halt && w_ref_done) begin
            r_cmp   <= 1'b1;
            r_state <= S_CHECK;
          end else if (r_cnt == TMO_END) begin
            r_cmp   <= 1'b0;
            r_tmo   <= 1'b1;
            r_err   <= w_err_inc;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_nxt;
          r_tc  <= w_tc_nxt[7:0];
          if (w_tc_nxt == LAST_TC) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 8'd0);
            r_state <= S_DONE;
          end else begin
            r_state <= S_GENX;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ProcReset_n = r_prst_n;
  assign Enter       = r_enter;
  assign Input       = r_input;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Pass        = r_pass;
  assign Timeout     = r_tmo;
  assign ErrCount    = r_err;
  assign TestCount   = r_tc;
  assign CurX        = r_curx;
  assign CurY        = r_cury;

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Bench for gcd_stim_driver: behavioural GCD processor plus a
// run-timeline model compared against the DUT outputs every cycle.
module tb_gcd_stim_driver;

  localparam int         NT  = 2;
  localparam logic [7:0] SD  = 8'h01;
  localparam int         LG1 = 4;
  localparam int         LG2 = 7;
  localparam int         TMO = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] outp = 8'd0;
  logic       prn, ent, busy, done, pass, tmo;
  logic [7:0] inp, err, tc, cx, cy;

  gcd_stim_driver #(
    .NUM_TESTS (NT),
    .SEED      (SD),
    .LOAD_GAP1 (LG1),
    .LOAD_GAP2 (LG2),
    .TIMEOUT   (TMO)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Start       (start),
    .Halt        (halt),
    .Output      (outp),
    .ProcReset_n (prn),
    .Enter       (ent),
    .Input       (inp),
    .Busy        (busy),
    .Done        (done),
    .Pass        (pass),
    .Timeout     (tmo),
    .ErrCount    (err),
    .TestCount   (tc),
    .CurX        (cx),
    .CurY        (cy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       prn;
    logic       ent;
    logic [7:0] inp;
    logic       busy;
    logic       done;
    logic       pass;
    logic       tmo;
    logic [7:0] err;
    logic [7:0] tc;
    logic [7:0] cx;
    logic [7:0] cy;
  } vec_t;

  vec_t       q[$];
  vec_t       hold;
  int         dq[$];
  logic [7:0] strobes[$];
  logic [7:0] m_lfsr;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int skips = 0, cyc = 0;
  int pmode = 0, pd = 0, ysince = -1, pcnt = 0;
  logic [7:0] px = 8'd0, py = 8'd0;

  function automatic logic [7:0] lstep(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] egcd(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return 8'(x);
  endfunction

  function automatic int nsub(input logic [7:0] a, input logic [7:0] b);
    int x, y, n;
    x = a; y = b; n = 0;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
      n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic vec_t dut_vec();
    return {prn, ent, inp, busy, done, pass, tmo, err, tc, cx, cy};
  endfunction

  function automatic logic [31:0] s4();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++)
      v = {v[23:0], (i < strobes.size()) ? strobes[i] : 8'h00};
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Expected output timeline of one whole run, from phase lengths
  task automatic build_run(input int dlo, input int dhi);
    vec_t e;
    int s, d, j;
    logic [7:0] g, o;
    bit th;
    e = hold;
    e.busy = 1; e.done = 0; e.pass = 0; e.tmo = 0;
    e.err = 0; e.tc = 0; e.ent = 0; e.prn = 1;
    for (int t = 0; t < NT; t++) begin
      do begin
        q.push_back(e);
        m_lfsr = lstep(m_lfsr);
        if (m_lfsr[6:0] == 7'd0) skips++;
      end while (m_lfsr[6:0] == 7'd0);
      e.cx = {1'b0, m_lfsr[6:0]};
      do begin
        q.push_back(e);
        m_lfsr = lstep(m_lfsr);
        if (m_lfsr[6:0] == 7'd0) skips++;
      end while (m_lfsr[6:0] == 7'd0);
      e.cy = {1'b0, m_lfsr[6:0]};
      e.prn = 0; q.push_back(e); e.prn = 1;
      repeat (LG1) q.push_back(e);
      e.ent = 1; e.inp = e.cx; q.push_back(e); e.ent = 0;
      repeat (LG2 - 1) q.push_back(e);
      e.ent = 1; e.inp = e.cy; q.push_back(e); e.ent = 0;
      d = int'($urandom_range(dhi, dlo));
      dq.push_back(d);
      s = nsub(e.cx, e.cy);
      g = egcd(e.cx, e.cy);
      j = s - LG1 - LG2 - 1;
      if (j < d) j = d;
      th = (pmode == 2) || (j >= TMO);
      if (th) j = TMO - 1;
      repeat (j + 1) q.push_back(e);
      if (th) begin e.tmo = 1; e.err = sat(e.err); end
      q.push_back(e);
      o = (pmode == 1) ? g + 8'd1 : g;
      if (!th && o != g) e.err = sat(e.err);
      e.tc = e.tc + 8'd1;
      if (t == NT - 1) begin
        e.busy = 0; e.done = 1; e.pass = (e.err == 8'd0);
      end
    end
    hold = e;
  endtask

  // Behavioural GCD processor reacting to the DUT's strobes
  task automatic proc_step();
    if (!prn) begin
      pcnt = 0; ysince = -1; halt = 0; outp = 8'd0;
    end else begin
      if (ent) begin
        strobes.push_back(inp);
        if (pcnt == 0) px = inp;
        else begin
          py = inp; ysince = 0;
          pd = (dq.size() > 0) ? dq.pop_front() : 0;
        end
        pcnt++;
      end else if (ysince >= 0) ysince++;
      halt = (pmode != 2) && (ysince >= 1) && (ysince - 1 >= pd);
      if (!halt) outp = 8'd0;
      else if (pmode == 1) outp = egcd(px, py) + 8'd1;
      else outp = egcd(px, py);
    end
  endtask

  task automatic cycle();
    vec_t ex;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) ex = q.pop_front();
    else ex = hold;
    check("cyc", 64'(dut_vec()), 64'(ex));
    start = 0;
    proc_step();
  endtask

  task automatic run(input int mode, input int dlo, input int dhi, input int mid);
    int n;
    pmode = mode;
    strobes.delete();
    start = 1;
    build_run(dlo, dhi);
    n = 0;
    while (q.size() > 0) begin
      cycle();
      n++;
      if (mid > 0 && n == mid) start = 1;
    end
    repeat (2) cycle();
  endtask

  initial begin
    int n, m;
    hold = '0;
    m_lfsr = SD;
    @(posedge clk);
    #1;
    check("reset_vals", 64'(dut_vec()), 64'd0);
    @(negedge clk);
    rst = 0;
    hold.prn = 1;
    repeat (3) cycle();

    run(0, 0, 40, 0);
    check("run1_strobes", 64'(s4()), 64'h02040811);
    check("run1_result", 64'({done, pass, tc, err}), 64'({1'b1, 1'b1, 8'd2, 8'd0}));

    run(1, 0, 40, 5);
    check("run2_ops", 64'(s4() >> 16), 64'h2347);
    check("run2_result", 64'({done, pass, err}), 64'({1'b1, 1'b0, 8'd2}));

    run(2, 0, 0, 0);
    check("run3_timeout", 64'({done, pass, tmo, err, tc}),
          64'({1'b1, 1'b0, 1'b1, 8'd2, 8'd2}));

    pmode = 0;
    strobes.delete();
    start = 1;
    build_run(30, 30);
    n = 0;
    while (strobes.size() < 2 && n < 200) begin cycle(); n++; end
    check("rst_reach_wait", 64'(strobes.size()), 64'd2);
    repeat (3) cycle();
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_mid", 64'(dut_vec()), 64'd0);
    halt = 0; outp = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", 64'({done, busy, prn}), 64'd0);
    @(negedge clk);
    rst = 0;
    q.delete(); dq.delete();
    m_lfsr = SD;
    hold = '0; hold.prn = 1;
    pcnt = 0; ysince = -1;
    repeat (3) cycle();

    run(0, 0, 40, 0);
    check("reseed_strobes", 64'(s4()), 64'h02040811);

    for (int r = 0; r < 80; r++) begin
      m = int'($urandom_range(9, 0));
      if (m < 6) m = 0;
      else if (m < 8) m = 1;
      else m = 2;
      run(m, 0, 40, int'($urandom_range(12, 2)));
    end
    check("zero_skip_seen", 64'(skips > 0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
